// File: rtl/regfile_pkg.sv
// Shared defaults and types for the scoreboarded register file.
// Build option: define REGFILE_BYPASS_EN for write-first read forwarding.
package regfile_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int REG_ZERO   = 0;

   typedef logic [DATA_W_DEF-1:0] data_t;
   typedef logic [ADDR_W_DEF-1:0] addr_t;
endpackage

// File: rtl/reg_busy_table.sv
// Pending-write scoreboard: one busy bit per register plus an exact popcount.
// A set and a clear of the same register in one cycle leaves the bit set.
module reg_busy_table
   import regfile_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = 1 << ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              set_en,
   input  logic [ADDR_W-1:0] set_addr,
   input  logic              clr_en,
   input  logic [ADDR_W-1:0] clr_addr,
   output logic [DEPTH-1:0]  busy,
   output logic [ADDR_W:0]   cnt
);
   logic inc, dec;

   // Count only real bit transitions so the counter never drifts from busy[].
   always_comb begin
      inc = set_en && !busy[set_addr];
      dec = clr_en && busy[clr_addr] && !(set_en && (set_addr == clr_addr));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy <= '0;
         cnt  <= '0;
      end else begin
         if (clr_en) busy[clr_addr] <= 1'b0;
         if (set_en) busy[set_addr] <= 1'b1;
         cnt <= cnt + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
      end
   end
endmodule

// File: rtl/registerfile_sb.sv
// Two-read/one-write register file with a pending-write scoreboard for hazard stalls.
// Build option: REGFILE_BYPASS_EN enables write-first forwarding of data and busy.
module registerfile_sb
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int ZERO_REG = 1
) (
   input  logic              clk_in,
   input  logic              reset_in,
   input  logic [ADDR_W-1:0] rs_in,
   input  logic [ADDR_W-1:0] rt_in,
   output logic [DATA_W-1:0] data_rs_out,
   output logic [DATA_W-1:0] data_rt_out,
   input  logic              regWrite_in,
   input  logic [ADDR_W-1:0] write_addr_in,
   input  logic [DATA_W-1:0] write_data_in,
   input  logic              issue_valid_in,
   input  logic [ADDR_W-1:0] issue_addr_in,
   output logic              rs_busy_out,
   output logic              rt_busy_out,
   output logic [ADDR_W:0]   pending_cnt_out
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic              wr_ok;
   logic              set_ok;

   function automatic logic is_zero(input logic [ADDR_W-1:0] a);
      return (ZERO_REG != 0) && (a == ADDR_W'(REG_ZERO));
   endfunction

   assign wr_ok  = regWrite_in && !reset_in && !is_zero(write_addr_in);
   assign set_ok = issue_valid_in && !is_zero(issue_addr_in);

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else if (wr_ok) begin
         regs[write_addr_in] <= write_data_in;
      end
   end

   reg_busy_table #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_busy (
      .clk      (clk_in),
      .reset    (reset_in),
      .set_en   (set_ok),
      .set_addr (issue_addr_in),
      .clr_en   (regWrite_in),
      .clr_addr (write_addr_in),
      .busy     (busy),
      .cnt      (pending_cnt_out)
   );

   always_comb begin
      data_rs_out = is_zero(rs_in) ? '0 : regs[rs_in];
      data_rt_out = is_zero(rt_in) ? '0 : regs[rt_in];
      rs_busy_out = busy[rs_in];
      rt_busy_out = busy[rt_in];
`ifdef REGFILE_BYPASS_EN
      // A same-cycle re-issue of the written register keeps the registered busy bit.
      if (wr_ok && (write_addr_in == rs_in)) begin
         data_rs_out = write_data_in;
         if (!(issue_valid_in && (issue_addr_in == rs_in))) rs_busy_out = 1'b0;
      end
      if (wr_ok && (write_addr_in == rt_in)) begin
         data_rt_out = write_data_in;
         if (!(issue_valid_in && (issue_addr_in == rt_in))) rt_busy_out = 1'b0;
      end
`endif
   end
endmodule

// File: tb/tb_registerfile_sb.sv
// Randomized scoreboard bench for registerfile_sb against an array/queue reference model.
module tb_registerfile_sb;
   logic        clk = 1'b0;
   logic        reset_in = 1'b1;
   logic [4:0]  rs_in = '0, rt_in = '0, write_addr_in = '0, issue_addr_in = '0;
   logic [31:0] write_data_in = '0;
   logic        regWrite_in = 1'b0, issue_valid_in = 1'b0;
   logic [31:0] data_rs_out, data_rt_out;
   logic        rs_busy_out, rt_busy_out;
   logic [5:0]  pending_cnt_out;

   always #5 clk = ~clk;

   registerfile_sb dut (
      .clk_in(clk), .reset_in(reset_in), .rs_in(rs_in), .rt_in(rt_in),
      .data_rs_out(data_rs_out), .data_rt_out(data_rt_out),
      .regWrite_in(regWrite_in), .write_addr_in(write_addr_in), .write_data_in(write_data_in),
      .issue_valid_in(issue_valid_in), .issue_addr_in(issue_addr_in),
      .rs_busy_out(rs_busy_out), .rt_busy_out(rt_busy_out), .pending_cnt_out(pending_cnt_out)
   );

   typedef struct {
      logic [31:0] drs, drt;
      logic        brs, brt;
      int          cnt;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] mem [32];
   bit          pend [32];
   int          vectors = 0, miscompares = 0;
   bit          stim_done = 0;

   function automatic int popcount_pend();
      int n = 0;
      foreach (pend[i]) n += pend[i];
      return n;
   endfunction

   // Advance the model by the edge that just consumed the held inputs.
   function automatic void model_edge();
      if (reset_in) begin
         foreach (mem[i]) mem[i] = '0;
         foreach (pend[i]) pend[i] = 0;
      end else begin
         if (regWrite_in && write_addr_in != 0) mem[write_addr_in] = write_data_in;
         if (regWrite_in) pend[write_addr_in] = 0;
         if (issue_valid_in && issue_addr_in != 0) pend[issue_addr_in] = 1;
      end
   endfunction

   function automatic void read_port(input logic [4:0] a, output logic [31:0] d, output logic b);
      d = (a == 0) ? 32'd0 : mem[a];
      b = pend[a];
`ifdef REGFILE_BYPASS_EN
      if (!reset_in && regWrite_in && write_addr_in != 0 && write_addr_in == a) begin
         d = write_data_in;
         if (!(issue_valid_in && issue_addr_in == a)) b = 0;
      end
`endif
   endfunction

   task automatic step(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic iv, input logic [4:0] ia, input logic [4:0] rs, input logic [4:0] rt);
      exp_t e;
      @(posedge clk);
      model_edge();
      #1;
      reset_in = r; regWrite_in = we; write_addr_in = wa; write_data_in = wd;
      issue_valid_in = iv; issue_addr_in = ia; rs_in = rs; rt_in = rt;
      read_port(rs, e.drs, e.brs);
      read_port(rt, e.drt, e.brt);
      e.cnt = popcount_pend();
      sb_q.push_back(e);
   endtask

   // Monitor: outputs are valid every cycle; compare mid-cycle against the queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            vectors++;
            if (data_rs_out !== e.drs) begin
               miscompares++;
               $display("FAIL data_rs rs=%0d got=%h exp=%h t=%0t", rs_in, data_rs_out, e.drs, $time);
            end
            if (data_rt_out !== e.drt) begin
               miscompares++;
               $display("FAIL data_rt rt=%0d got=%h exp=%h t=%0t", rt_in, data_rt_out, e.drt, $time);
            end
            if (rs_busy_out !== e.brs) begin
               miscompares++;
               $display("FAIL rs_busy rs=%0d got=%b exp=%b t=%0t", rs_in, rs_busy_out, e.brs, $time);
            end
            if (rt_busy_out !== e.brt) begin
               miscompares++;
               $display("FAIL rt_busy rt=%0d got=%b exp=%b t=%0t", rt_in, rt_busy_out, e.brt, $time);
            end
            if (pending_cnt_out !== 6'(e.cnt)) begin
               miscompares++;
               $display("FAIL pending_cnt got=%0d exp=%0d t=%0t", pending_cnt_out, e.cnt, $time);
            end
         end
      end
   end

   initial begin
      foreach (mem[i]) mem[i] = '0;
      foreach (pend[i]) pend[i] = 0;
      // Reset after random writes and issues
      step(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++)
         step(0, 1, 5'($urandom_range(1, 31)), $urandom, 1, 5'($urandom_range(1, 31)), 5'(i), 5'(i + 8));
      step(1, 1, 7, 32'h1234, 1, 9, 7, 9);
      for (int i = 0; i < 32; i += 2) step(0, 0, 0, 0, 0, 0, 5'(i), 5'(i + 1));
      // r3 write then read back
      step(0, 1, 3, 100, 0, 0, 3, 3);
      step(0, 0, 0, 0, 0, 0, 3, 0);
      // register zero ignores writes and issues
      step(0, 1, 0, 32'hDEAD, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      // issue r6, write-back clears it
      step(0, 0, 0, 0, 1, 6, 6, 6);
      step(0, 1, 6, 100, 0, 0, 6, 6);
      step(0, 0, 0, 0, 0, 0, 6, 6);
      // r5 busy, then issued and written together
      step(0, 0, 0, 0, 1, 5, 5, 5);
      step(0, 1, 5, 55, 1, 5, 5, 5);
      step(0, 0, 0, 0, 0, 0, 5, 5);
      step(0, 1, 5, 56, 0, 0, 5, 5);
      // fill scoreboard, then reset mid-sequence
      step(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 1; i < 32; i++) step(0, 0, 0, 0, 1, 5'(i), 5'(i), 5'(i - 1));
      step(0, 0, 0, 0, 0, 0, 31, 1);
      for (int i = 1; i < 16; i++) step(0, 1, 5'(i), $urandom, 1, 5'(i + 16), 5'(i), 5'(i + 16));
      step(1, 0, 0, 0, 1, 20, 20, 0);
      step(0, 0, 0, 0, 1, 12, 12, 20);
      step(0, 0, 0, 0, 0, 0, 12, 20);
      // random traffic, narrow address window half the time to force collisions
      for (int i = 0; i < 3000; i++) begin
         int hi = ($urandom_range(0, 1) == 1) ? 3 : 31;
         step(($urandom_range(0, 63) == 0), 1'($urandom), 5'($urandom_range(0, hi)), $urandom,
              1'($urandom), 5'($urandom_range(0, hi)), 5'($urandom_range(0, hi)), 5'($urandom_range(0, hi)));
      end
      repeat (3) @(posedge clk);
      if (sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain queued=%0d exp=0", sb_q.size());
      end
      stim_done = 1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      if (!stim_done) begin
         $display("FAIL watchdog stimulus not complete at t=%0t", $time);
         $fatal(1);
      end
   end
endmodule
